// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared types, defaults and helpers for the button debouncer
//
// Contents:
//   deb_state_t        per-channel filter FSM state encoding
//   DEF_*              default timing constants for a 50 MHz clock
//   cnt_width()        width of a counter able to hold the largest timing constant
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_LOW      = 2'b00,
        ST_CHK_HIGH = 2'b01,
        ST_HIGH     = 2'b10,
        ST_CHK_LOW  = 2'b11
    } deb_state_t;

    localparam int DEF_STABLE_CYCLES = 1_000_000;
    localparam int DEF_REPEAT_DELAY  = 25_000_000;
    localparam int DEF_REPEAT_PERIOD = 10_000_000;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one button channel: synchroniser, bounce filter, edge and step pulses
//
// Optional feature macro: DEBOUNCE_AUTOREPEAT_EN (auto-repeat step pulses while held)
//
// Ports:
//   clk_50M  in   system clock
//   rst      in   synchronous active-high reset
//   button   in   raw asynchronous button, active-high
//   level    out  debounced level
//   rise     out  one-cycle pulse on debounced 0->1
//   fall     out  one-cycle pulse on debounced 1->0
//   step     out  press pulse plus optional auto-repeat pulses
import debounce_pkg::*;

module debounce_channel #(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic clk_50M,
    input  logic rst,
    input  logic button,
    output logic level,
    output logic rise,
    output logic fall,
    output logic step
);

    localparam int CW = cnt_width(STABLE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [CW-1:0] CNT_MAX     = {CW{1'b1}};
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);

    logic          s1, s2;
    deb_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          rise_nxt, fall_nxt, level_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        case (state)
            ST_LOW: begin
                if (s2) begin
                    state_nxt = ST_CHK_HIGH;
                    cnt_nxt   = CNT_ONE;
                end
            end
            ST_CHK_HIGH: begin
                if (!s2) begin
                    state_nxt = ST_LOW;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = ST_HIGH;
                    cnt_nxt   = '0;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (!s2) begin
                    state_nxt = ST_CHK_LOW;
                    cnt_nxt   = CNT_ONE;
                end
            end
            ST_CHK_LOW: begin
                if (s2) begin
                    state_nxt = ST_HIGH;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = ST_LOW;
                    cnt_nxt   = '0;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = ST_LOW;
                cnt_nxt   = '0;
            end
        endcase
        // A release still being qualified keeps the level high.
        level_nxt = (state_nxt == ST_HIGH) || (state_nxt == ST_CHK_LOW);
    end

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= ST_LOW;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            s1    <= button;
            s2    <= s1;
            state <= state_nxt;
            cnt   <= cnt_nxt;
            level <= level_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
        end
    end

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam logic [CW-1:0] DELAY_L  = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] PERIOD_L = CW'(REPEAT_PERIOD);

    logic [CW-1:0] rcnt, rcnt_nxt, rcnt_inc;
    logic          rep, rep_nxt, step_nxt;

    // rcnt restarts after every step; rep selects the first-delay or
    // steady-period threshold, so the counter never has to wrap.
    always_comb begin
        rcnt_nxt = rcnt;
        rep_nxt  = rep;
        step_nxt = rise_nxt;
        rcnt_inc = (rcnt == CNT_MAX) ? rcnt : rcnt + CNT_ONE;
        if (((state == ST_HIGH) || (state == ST_CHK_LOW)) && !fall_nxt) begin
            if (rcnt_inc == (rep ? PERIOD_L : DELAY_L)) begin
                step_nxt = 1'b1;
                rcnt_nxt = '0;
                rep_nxt  = 1'b1;
            end else begin
                rcnt_nxt = rcnt_inc;
            end
        end else begin
            rcnt_nxt = '0;
            rep_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            rcnt <= '0;
            rep  <= 1'b0;
            step <= 1'b0;
        end else begin
            rcnt <= rcnt_nxt;
            rep  <= rep_nxt;
            step <= step_nxt;
        end
    end
`else
    assign step = rise;
`endif

endmodule

// File: rtl/multi_channel_debouncer.sv
// rtl/multi_channel_debouncer.sv - N independent debounced push-button channels
//
// Optional feature macro: DEBOUNCE_AUTOREPEAT_EN (auto-repeat on o_step)
//
// Ports:
//   clk_50M   in   system clock
//   rst       in   synchronous active-high reset
//   i_button  in   [CHANNELS] raw asynchronous buttons, active-high
//   o_level   out  [CHANNELS] debounced levels
//   o_rise    out  [CHANNELS] one-cycle debounced press pulses
//   o_fall    out  [CHANNELS] one-cycle debounced release pulses
//   o_step    out  [CHANNELS] step pulses (press plus optional auto-repeat)
import debounce_pkg::*;

module multi_channel_debouncer #(
    parameter int CHANNELS      = 4,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic                clk_50M,
    input  logic                rst,
    input  logic [CHANNELS-1:0] i_button,
    output logic [CHANNELS-1:0] o_level,
    output logic [CHANNELS-1:0] o_rise,
    output logic [CHANNELS-1:0] o_fall,
    output logic [CHANNELS-1:0] o_step
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_ch (
            .clk_50M (clk_50M),
            .rst     (rst),
            .button  (i_button[g]),
            .level   (o_level[g]),
            .rise    (o_rise[g]),
            .fall    (o_fall[g]),
            .step    (o_step[g])
        );
    end

endmodule
